// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises an NBYTES-byte word as back-to-back 8N1 frames,
// most significant byte first, bits within each byte LSB first.

module uart_word_tx_chk #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NBYTES       = 6,
  parameter int BAUD_W       = 9,
  parameter int BYTE_W       = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_uart_tx,
  input  logic              i_busy,
  input  logic              i_trans_done,
  input  logic [BAUD_W-1:0] i_baud_cnt,
  input  logic [BYTE_W-1:0] i_byte_cnt
);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  a_done_one_cycle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_trans_done |=> !i_trans_done);

  a_idle_line_high: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !i_busy |-> i_uart_tx);

  a_baud_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_baud_cnt <= BAUD_LAST);

  a_byte_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_byte_cnt <= BYTE_LAST);
endmodule

module uart_word_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NBYTES       = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_start,
  input  logic [8*NBYTES-1:0] uart_data_in,
  output logic                uart_tx,
  output logic                busy,
  output logic                trans_done
);
  localparam int W      = 8 * NBYTES;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W-1:0]      r_shift;
  logic [W-1:0]      w_shift_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_nxt;
  logic [BYTE_W-1:0] r_byte;
  logic [BYTE_W-1:0] w_byte_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_baud_wrap;
  logic              w_last_byte;
  logic              w_accept;
  logic [7:0]        w_cur_byte;

  // The byte on the wire is always the top byte; the register shifts up between bytes.
  assign w_cur_byte  = r_shift[W-1 -: 8];
  assign w_baud_wrap = (r_baud == BAUD_LAST);
  assign w_last_byte = (r_byte == BYTE_LAST);
  // A word is taken from IDLE, or straight out of the final stop bit for gapless chaining.
  assign w_accept    = tx_start &&
                       ((r_state == IDLE) ||
                        ((r_state == STOP) && w_baud_wrap && w_last_byte));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    if (w_accept) begin
      w_state_nxt = START;
      w_shift_nxt = uart_data_in;
      w_baud_nxt  = '0;
      w_bit_nxt   = 3'd0;
      w_byte_nxt  = '0;
      w_tx_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = (r_state == STOP);
    end else begin
      case (r_state)
        IDLE: begin
          w_tx_nxt   = 1'b1;
          w_busy_nxt = 1'b0;
        end
        START: begin
          if (w_baud_wrap) begin
            w_state_nxt = DATA;
            w_baud_nxt  = '0;
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = w_cur_byte[0];
          end else begin
            w_baud_nxt  = r_baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (w_baud_wrap) begin
            w_baud_nxt = '0;
            if (r_bit == 3'd7) begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end else begin
              w_bit_nxt   = r_bit + 3'd1;
              w_tx_nxt    = w_cur_byte[w_bit_nxt];
            end
          end else begin
            w_baud_nxt = r_baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (w_baud_wrap) begin
            w_baud_nxt = '0;
            if (!w_last_byte) begin
              w_state_nxt = START;
              w_byte_nxt  = r_byte + BYTE_W'(1);
              w_shift_nxt = r_shift << 4'd8;
              w_bit_nxt   = 3'd0;
              w_tx_nxt    = 1'b0;
            end else begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_baud_nxt = r_baud + BAUD_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign trans_done = r_done;

  uart_word_tx_chk #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .NBYTES       (NBYTES),
    .BAUD_W       (BAUD_W),
    .BYTE_W       (BYTE_W)
  ) u_chk (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_uart_tx    (r_tx),
    .i_busy       (r_busy),
    .i_trans_done (r_done),
    .i_baud_cnt   (r_baud),
    .i_byte_cnt   (r_byte)
  );
endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter NBYTES, default 6, bytes per word; data width is 8*NBYTES.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port tx_start, input, 1, request to send one word; level-sampled each cycle.
REQ-006 SHALL have port uart_data_in, input, 8*NBYTES, word to send; bit 47 carries the sign and is sent first.
REQ-007 SHALL have port uart_tx, output, 1, serial line: 8N1 framing, idle high.
REQ-008 SHALL have port busy, output, 1, high from word acceptance until trans_done.
REQ-009 SHALL have port trans_done, output, 1, one-cycle pulse when the whole word has been sent.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-011 SHALL, in IDLE with tx_start=1 at edge k:
- latch uart_data_in into a shift register;
- clear the byte counter and the baud counter;
- enter START, with uart_tx=0 and busy=1 from edge k.
REQ-012 SHALL ignore tx_start while busy=1; the latched word SHALL NOT change mid-word.
REQ-013 SHALL send bytes MSB-byte first: byte 0 = data[47:40], last = data[7:0].
REQ-014 SHALL send the bits within each byte LSB first.
REQ-015 SHALL hold each bit (start, 8 data, stop) on uart_tx for exactly CLKS_PER_BIT cycles, timed by the baud counter, which counts 0..CLKS_PER_BIT-1 and wraps.
REQ-016 SHALL, on baud counter wrap, advance as follows:
- START -> DATA;
- DATA bit 7 -> STOP;
- STOP -> START if the byte counter < NBYTES-1, else IDLE.
REQ-017 SHALL send consecutive bytes with no idle gap; each byte is exactly 10*CLKS_PER_BIT cycles.
REQ-018 SHALL make the word last exactly 10*NBYTES*CLKS_PER_BIT cycles, from the edge uart_tx falls for byte 0 to the edge the FSM re-enters IDLE.
REQ-019 SHALL, at the edge the final stop bit ends, return to IDLE and assert trans_done=1 and busy=0 for one cycle; trans_done SHALL be 0 at all other times.
REQ-020 SHALL accept tx_start asserted in the trans_done cycle as a new word at that edge, giving back-to-back words with no idle bit.
REQ-021 SHALL drive uart_tx from a register with no combinational path from inputs.
REQ-022 SHALL use a baud counter width of clog2(CLKS_PER_BIT), a bit counter of 3 bits and a byte counter of clog2(NBYTES); no counter SHALL overflow outside its stated range.

Reset
REQ-023 SHALL, on rst_n=0, immediately force:
- state IDLE, uart_tx=1, busy=0, trans_done=0;
- all counters and the shift register to 0.
REQ-024 SHALL, on reset asserted mid-word, abort the frame, drive uart_tx high, and never assert trans_done for the aborted word.
REQ-025 SHALL resume accepting tx_start on the first rising edge after rst_n deasserts.

Verification (CLKS_PER_BIT=4, NBYTES=6)
REQ-026 SHALL cover: pulse tx_start with data 0x8000_0000_0001 -> line carries 0,0000_0001,1 then four bytes 0,0000_0000,1, then 0,1000_0000,1, each bit 4 cycles; trans_done pulses 240 cycles after the start edge.
REQ-027 SHALL cover: hold tx_start=1 continuously with data 0xA5A5_A5A5_A5A5 -> words repeat with exactly 240 cycles per word, no idle bit between them, and trans_done pulses at 240-cycle spacing.
REQ-028 SHALL cover: a new tx_start with a different value at cycle 50 of an active word -> it is ignored, and the current word and its timing are unchanged.
REQ-029 SHALL cover: rst_n low at cycle 100 of a word -> uart_tx=1, busy=0 asynchronously, no trans_done; a following tx_start sends a full correct word.
REQ-030 SHALL cover: data 0xFFFF_FFFF_FFFF -> only the start bits are low, the line is otherwise high, and the bit boundaries match REQ-015.
REQ-031 SHALL cover: tx_start=0 for 1000 cycles after reset -> uart_tx stays 1, busy=0, trans_done=0.
